mips_multicycle_control: RTL and testbench
==========================================

MIPS_MULTICYCLE_CONTROL -- requirements
Module: mips_multicycle_control

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 reset  input  1  asynchronous, active-high; one clock domain, no other clocks.
REQ-003 in_Opcode_6  input  6  instruction-register opcode, stable from DECODE onward.
REQ-004 in_Funct_6  input  6  instruction-register funct field.
REQ-005 in_Zero  input  1  ALU zero flag (result == 0).
REQ-006 in_MemReady  input  1  memory handshake; access completes on the cycle it is high.
REQ-007 o_ALUOperation_4  output  4  ALU code: AND 0000, OR 0001, NOR 0010, ADD 0011, SUB 0100, SLL 0101, SRL 0110, LUI 0111.
REQ-008 o_PCWrite, o_IorD, o_MemRead, o_MemWrite, o_IRWrite, o_RegWrite, o_RegDst, o_MemtoReg, o_ALUSrcA, o_ExtZero  outputs  1 each  datapath strobes/selects.
REQ-009 o_ALUSrcB_2  output  2  00 regB, 01 const 4, 10 extended imm, 11 imm<<2.
REQ-010 o_PCSource_2  output  2  00 ALU result, 01 ALUOut, 10 jump target.
REQ-011 o_State_4  output  4  current state encoding (debug).
REQ-012 o_Trap  output  1  illegal-instruction indicator (see Configuration).

Function
REQ-013 States SHALL be FETCH 0, DECODE 1, MEMADDR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, REXEC 6, IEXEC 7, ALUWB 8, BRANCH 9, JUMP 10, TRAP 11; one state register.
REQ-014 Unlisted strobes SHALL be 0 in every state; selects default to 0; o_ALUOperation_4 defaults to ADD.
REQ-015 FETCH: MemRead=1, IorD=0, SrcA=0, SrcB=01, ADD; IRWrite=PCWrite=in_MemReady; stays in FETCH until in_MemReady, then DECODE.
REQ-016 DECODE: SrcA=0, SrcB=11, ADD; next state by opcode: 0x00 REXEC; 0x23/0x2B MEMADDR; 0x08/0x0C/0x0D/0x0F IEXEC; 0x04/0x05 BRANCH; 0x02 JUMP; other illegal.
REQ-017 REXEC: SrcA=1, SrcB=00; funct 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x27 NOR, 0x00 SLL, 0x02 SRL -> ALUWB; other funct illegal.
REQ-018 IEXEC: SrcA=1, SrcB=10; addi ADD, andi AND, ori OR, lui LUI; ExtZero=1 for andi/ori/lui -> ALUWB.
REQ-019 ALUWB: RegWrite=1, MemtoReg=0, RegDst=1 iff opcode 0x00, ALU code held from execute state -> FETCH.
REQ-020 MEMADDR: SrcA=1, SrcB=10, ADD -> MEMREAD (lw) or MEMWRITE (sw).
REQ-021 MEMREAD: IorD=1, MemRead=1; hold until in_MemReady, then MEMWB. MEMWB: RegWrite=1, MemtoReg=1, RegDst=0 -> FETCH.
REQ-022 MEMWRITE: IorD=1, MemWrite=1; hold until in_MemReady -> FETCH.
REQ-023 BRANCH: SrcA=1, SrcB=00, SUB, PCSource=01; PCWrite=in_Zero (beq) or ~in_Zero (bne), same cycle -> FETCH.
REQ-024 JUMP: PCSource=10, PCWrite=1 -> FETCH.
REQ-025 Latency SHALL be, with zero wait states: R/I-type 4, lw 5, sw 4, branch 3, jump 3 cycles; each in_MemReady-low cycle adds one.
REQ-026 Outputs SHALL be Moore-decoded from state/opcode/funct except PCWrite/IRWrite, which combine in_MemReady/in_Zero.

Reset
REQ-027 reset high SHALL force FETCH immediately, regardless of clk or in-flight access, with o_Trap=0 and all write strobes 0 while asserted.
REQ-028 After deassertion the first rising edge SHALL evaluate FETCH normally.

Configuration
REQ-029 Macro MIPS_CTRL_ILLEGAL_TRAP_EN defined: illegal opcode/funct enters TRAP; TRAP drives all strobes 0, o_Trap=1, stays until reset.
REQ-030 Macro undefined: illegal opcode/funct returns to FETCH (NOP); TRAP unreachable; o_Trap tied 0.

Verification
REQ-031 add (op 0x00, funct 0x20), in_MemReady=1 -> states 0,1,6,8,0; ALUOperation 0011 in REXEC; RegWrite=1, RegDst=1 in ALUWB only.
REQ-032 lw (0x23), in_MemReady low 2 cycles in MEMREAD -> MEMREAD held 3 cycles, MemtoReg=1 RegWrite=1 in MEMWB, total 7 cycles.
REQ-033 beq with in_Zero=1 -> PCWrite=1, PCSource=01 in BRANCH; bne with in_Zero=1 -> PCWrite=0.
REQ-034 lui (0x0F) -> ALUOperation 0111, ExtZero=1, SrcB=10 in IEXEC.
REQ-035 Opcode 0x3F: with macro -> o_Trap=1, state 11 held 10 cycles; without -> FETCH after DECODE, o_Trap=0.
REQ-036 reset asserted mid-MEMWRITE -> state 0 and MemWrite=0 before next clk edge.

Source files
------------

// File: rtl/mips_multicycle_control_if.sv
// Control/status bundle between the multicycle MIPS controller and its datapath.
// The master side is the controller; the slave side is the datapath (or a bench).
interface mips_multicycle_control_if;
    logic [5:0] in_Opcode_6;
    logic [5:0] in_Funct_6;
    logic       in_Zero;
    logic       in_MemReady;

    logic [3:0] o_ALUOperation_4;
    logic       o_PCWrite;
    logic       o_IorD;
    logic       o_MemRead;
    logic       o_MemWrite;
    logic       o_IRWrite;
    logic       o_RegWrite;
    logic       o_RegDst;
    logic       o_MemtoReg;
    logic       o_ALUSrcA;
    logic       o_ExtZero;
    logic [1:0] o_ALUSrcB_2;
    logic [1:0] o_PCSource_2;
    logic [3:0] o_State_4;
    logic       o_Trap;

    modport master (
        input  in_Opcode_6, in_Funct_6, in_Zero, in_MemReady,
        output o_ALUOperation_4, o_PCWrite, o_IorD, o_MemRead, o_MemWrite, o_IRWrite,
               o_RegWrite, o_RegDst, o_MemtoReg, o_ALUSrcA, o_ExtZero, o_ALUSrcB_2,
               o_PCSource_2, o_State_4, o_Trap
    );

    modport slave (
        output in_Opcode_6, in_Funct_6, in_Zero, in_MemReady,
        input  o_ALUOperation_4, o_PCWrite, o_IorD, o_MemRead, o_MemWrite, o_IRWrite,
               o_RegWrite, o_RegDst, o_MemtoReg, o_ALUSrcA, o_ExtZero, o_ALUSrcB_2,
               o_PCSource_2, o_State_4, o_Trap
    );
endinterface

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control FSM (Moore outputs, PCWrite/IRWrite qualified by handshake/zero).
// Define MIPS_CTRL_ILLEGAL_TRAP_EN to make illegal opcode/funct lock into TRAP until reset.
module mips_multicycle_control (
    input logic                         clk,
    input logic                         reset,
    mips_multicycle_control_if.master   bus
);

    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAddr  = 4'd2,
        StMemRead  = 4'd3,
        StMemWb    = 4'd4,
        StMemWrite = 4'd5,
        StRExec    = 4'd6,
        StIExec    = 4'd7,
        StAluWb    = 4'd8,
        StBranch   = 4'd9,
        StJump     = 4'd10,
        StTrap     = 4'd11
    } state_e;

`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
    localparam state_e StIllegal = StTrap;
`else
    localparam state_e StIllegal = StFetch;
`endif

    localparam logic [5:0] OpRType = 6'h00;
    localparam logic [5:0] OpJ     = 6'h02;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpBne   = 6'h05;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpAndi  = 6'h0C;
    localparam logic [5:0] OpOri   = 6'h0D;
    localparam logic [5:0] OpLui   = 6'h0F;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2B;

    localparam logic [5:0] FnSll = 6'h00;
    localparam logic [5:0] FnSrl = 6'h02;
    localparam logic [5:0] FnAdd = 6'h20;
    localparam logic [5:0] FnSub = 6'h22;
    localparam logic [5:0] FnAnd = 6'h24;
    localparam logic [5:0] FnOr  = 6'h25;
    localparam logic [5:0] FnNor = 6'h27;

    localparam logic [3:0] AluAnd = 4'b0000;
    localparam logic [3:0] AluOr  = 4'b0001;
    localparam logic [3:0] AluNor = 4'b0010;
    localparam logic [3:0] AluAdd = 4'b0011;
    localparam logic [3:0] AluSub = 4'b0100;
    localparam logic [3:0] AluSll = 4'b0101;
    localparam logic [3:0] AluSrl = 4'b0110;
    localparam logic [3:0] AluLui = 4'b0111;

    localparam logic [1:0] SrcBReg   = 2'b00;
    localparam logic [1:0] SrcBFour  = 2'b01;
    localparam logic [1:0] SrcBImm   = 2'b10;
    localparam logic [1:0] SrcBImmSh = 2'b11;

    localparam logic [1:0] PcSrcAluOut = 2'b01;
    localparam logic [1:0] PcSrcJump   = 2'b10;

    state_e     state_q, state_d;
    logic [5:0] opcode, funct;
    logic       zero, mem_ready;
    logic       is_rtype, funct_ok, imm_zext;
    logic [3:0] alu_r, alu_i;

    logic       pc_write, iord, mem_read, mem_write, ir_write, reg_write;
    logic       reg_dst, mem_to_reg, alu_src_a, ext_zero, trap;
    logic [1:0] alu_src_b, pc_source;
    logic [3:0] alu_op;

    assign opcode    = bus.in_Opcode_6;
    assign funct     = bus.in_Funct_6;
    assign zero      = bus.in_Zero;
    assign mem_ready = bus.in_MemReady;
    assign is_rtype  = (opcode == OpRType);

    // R-type ALU code from funct; unknown funct is flagged illegal and falls back to ADD.
    always_comb begin
        funct_ok = 1'b1;
        alu_r    = AluAdd;
        case (funct)
            FnAdd:   alu_r = AluAdd;
            FnSub:   alu_r = AluSub;
            FnAnd:   alu_r = AluAnd;
            FnOr:    alu_r = AluOr;
            FnNor:   alu_r = AluNor;
            FnSll:   alu_r = AluSll;
            FnSrl:   alu_r = AluSrl;
            default: funct_ok = 1'b0;
        endcase
    end

    always_comb begin
        alu_i    = AluAdd;
        imm_zext = 1'b0;
        case (opcode)
            OpAndi:  begin alu_i = AluAnd; imm_zext = 1'b1; end
            OpOri:   begin alu_i = AluOr;  imm_zext = 1'b1; end
            OpLui:   begin alu_i = AluLui; imm_zext = 1'b1; end
            default: alu_i = AluAdd;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StFetch:    if (mem_ready) state_d = StDecode;
            StDecode: begin
                case (opcode)
                    OpRType:                     state_d = StRExec;
                    OpLw, OpSw:                  state_d = StMemAddr;
                    OpAddi, OpAndi, OpOri, OpLui: state_d = StIExec;
                    OpBeq, OpBne:                state_d = StBranch;
                    OpJ:                         state_d = StJump;
                    default:                     state_d = StIllegal;
                endcase
            end
            StMemAddr:  state_d = (opcode == OpSw) ? StMemWrite : StMemRead;
            StMemRead:  if (mem_ready) state_d = StMemWb;
            StMemWb:    state_d = StFetch;
            StMemWrite: if (mem_ready) state_d = StFetch;
            StRExec:    state_d = funct_ok ? StAluWb : StIllegal;
            StIExec:    state_d = StAluWb;
            StAluWb:    state_d = StFetch;
            StBranch:   state_d = StFetch;
            StJump:     state_d = StFetch;
            // Sticky when trapping is built in, otherwise an unreachable state that self-clears.
            StTrap:     state_d = StIllegal;
            default:    state_d = StFetch;
        endcase
    end

    always_comb begin
        pc_write   = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        ext_zero   = 1'b0;
        alu_src_b  = SrcBReg;
        pc_source  = 2'b00;
        alu_op     = AluAdd;
        unique case (state_q)
            StFetch: begin
                mem_read  = 1'b1;
                alu_src_b = SrcBFour;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            StDecode:   alu_src_b = SrcBImmSh;
            StMemAddr: begin
                alu_src_a = 1'b1;
                alu_src_b = SrcBImm;
            end
            StMemRead: begin
                iord     = 1'b1;
                mem_read = 1'b1;
            end
            StMemWb: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            StMemWrite: begin
                iord      = 1'b1;
                mem_write = 1'b1;
            end
            StRExec: begin
                alu_src_a = 1'b1;
                alu_op    = alu_r;
            end
            StIExec: begin
                alu_src_a = 1'b1;
                alu_src_b = SrcBImm;
                alu_op    = alu_i;
                ext_zero  = imm_zext;
            end
            StAluWb: begin
                reg_write = 1'b1;
                reg_dst   = is_rtype;
                alu_op    = is_rtype ? alu_r : alu_i;
            end
            StBranch: begin
                alu_src_a = 1'b1;
                alu_op    = AluSub;
                pc_source = PcSrcAluOut;
                pc_write  = (opcode == OpBne) ? ~zero : zero;
            end
            StJump: begin
                pc_source = PcSrcJump;
                pc_write  = 1'b1;
            end
            default: ;
        endcase
        // FETCH is forced during reset, but its handshake-driven writes must stay quiet.
        if (reset) begin
            pc_write  = 1'b0;
            ir_write  = 1'b0;
            mem_write = 1'b0;
            reg_write = 1'b0;
        end
    end

`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
    assign trap = (state_q == StTrap) && !reset;
`else
    assign trap = 1'b0;
`endif

    assign bus.o_ALUOperation_4 = alu_op;
    assign bus.o_PCWrite        = pc_write;
    assign bus.o_IorD           = iord;
    assign bus.o_MemRead        = mem_read;
    assign bus.o_MemWrite       = mem_write;
    assign bus.o_IRWrite        = ir_write;
    assign bus.o_RegWrite       = reg_write;
    assign bus.o_RegDst         = reg_dst;
    assign bus.o_MemtoReg       = mem_to_reg;
    assign bus.o_ALUSrcA        = alu_src_a;
    assign bus.o_ExtZero        = ext_zero;
    assign bus.o_ALUSrcB_2      = alu_src_b;
    assign bus.o_PCSource_2     = pc_source;
    assign bus.o_State_4        = state_q;
    assign bus.o_Trap           = trap;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed bench for mips_multicycle_control: instruction table plus wait-state,
// reset and illegal-instruction sequences.
module tb_mips_multicycle_control;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mips_multicycle_control_if bus ();

    mips_multicycle_control dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string           name;
        logic [5:0]      op;
        logic [5:0]      fn;
        logic            z;
        int              len;
        logic [0:5][3:0] seq;   // expected state per cycle, first hex digit is cycle 0
        logic [3:0]      x_alu; // cycle-2 (execute) expectations
        logic            x_sa;
        logic [1:0]      x_sb;
        logic            x_ez;
        logic [3:0]      l_alu; // final-cycle expectations
        logic            l_pcw;
        logic [1:0]      l_pcs;
        logic            l_rw;
        logic            l_rd;
        logic            l_m2r;
        logic            l_mw;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string n, logic [5:0] op, logic [5:0] fn, logic z, int len,
                                logic [0:5][3:0] seq, logic [3:0] xa, logic xsa,
                                logic [1:0] xsb, logic xez, logic [3:0] la, logic pcw,
                                logic [1:0] pcs, logic rw, logic rd, logic m2r, logic mw);
        vec_t v;
        v.name = n; v.op = op; v.fn = fn; v.z = z; v.len = len; v.seq = seq;
        v.x_alu = xa; v.x_sa = xsa; v.x_sb = xsb; v.x_ez = xez;
        v.l_alu = la; v.l_pcw = pcw; v.l_pcs = pcs; v.l_rw = rw; v.l_rd = rd;
        v.l_m2r = m2r; v.l_mw = mw;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic z,
                         input logic mr);
        bus.in_Opcode_6 = op;
        bus.in_Funct_6  = fn;
        bus.in_Zero     = z;
        bus.in_MemReady = mr;
    endtask

    // Entered just after a rising edge with the FSM in FETCH; leaves it the same way.
    task automatic run_vec(input vec_t v);
        for (int c = 0; c < v.len; c++) begin
            drive(v.op, v.fn, v.z, 1'b1);
            @(negedge clk);
            chk($sformatf("%s state c%0d", v.name, c), 8'(bus.o_State_4), 8'(v.seq[c]));
            if (c == 0) begin
                chk({v.name, " fetch memread"}, 8'(bus.o_MemRead), 8'd1);
                chk({v.name, " fetch irwrite"}, 8'(bus.o_IRWrite), 8'd1);
                chk({v.name, " fetch pcwrite"}, 8'(bus.o_PCWrite), 8'd1);
                chk({v.name, " fetch srcb"}, 8'(bus.o_ALUSrcB_2), 8'd1);
                chk({v.name, " fetch alu"}, 8'(bus.o_ALUOperation_4), 8'd3);
            end
            if (c == 1) begin
                chk({v.name, " decode srca"}, 8'(bus.o_ALUSrcA), 8'd0);
                chk({v.name, " decode srcb"}, 8'(bus.o_ALUSrcB_2), 8'd3);
            end
            if (c == 2) begin
                chk({v.name, " exec alu"}, 8'(bus.o_ALUOperation_4), 8'(v.x_alu));
                chk({v.name, " exec srca"}, 8'(bus.o_ALUSrcA), 8'(v.x_sa));
                chk({v.name, " exec srcb"}, 8'(bus.o_ALUSrcB_2), 8'(v.x_sb));
                chk({v.name, " exec extzero"}, 8'(bus.o_ExtZero), 8'(v.x_ez));
            end
            if (c == v.len - 1) begin
                chk({v.name, " last alu"}, 8'(bus.o_ALUOperation_4), 8'(v.l_alu));
                chk({v.name, " last pcwrite"}, 8'(bus.o_PCWrite), 8'(v.l_pcw));
                chk({v.name, " last pcsource"}, 8'(bus.o_PCSource_2), 8'(v.l_pcs));
                chk({v.name, " last regwrite"}, 8'(bus.o_RegWrite), 8'(v.l_rw));
                chk({v.name, " last regdst"}, 8'(bus.o_RegDst), 8'(v.l_rd));
                chk({v.name, " last memtoreg"}, 8'(bus.o_MemtoReg), 8'(v.l_m2r));
                chk({v.name, " last memwrite"}, 8'(bus.o_MemWrite), 8'(v.l_mw));
            end
            @(posedge clk);
            #1;
        end
        chk({v.name, " back to fetch"}, 8'(bus.o_State_4), 8'd0);
        bus.in_MemReady = 1'b0;
    endtask

    task automatic reset_pulse(input string nm);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk({nm, " reset state"}, 8'(bus.o_State_4), 8'd0);
        chk({nm, " reset trap"}, 8'(bus.o_Trap), 8'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        bus.in_MemReady = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Illegal opcode/funct: steps through legal states, then traps or falls back to FETCH.
    task automatic run_illegal(input string nm, input logic [5:0] op, input logic [5:0] fn,
                               input int pre);
        for (int c = 0; c < pre; c++) begin
            drive(op, fn, 1'b0, 1'b1);
            @(posedge clk);
            #1;
        end
        bus.in_MemReady = 1'b0;
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk($sformatf("%s trap state c%0d", nm, c), 8'(bus.o_State_4), 8'd11);
            chk($sformatf("%s trap flag c%0d", nm, c), 8'(bus.o_Trap), 8'd1);
        end
        chk({nm, " trap memread"}, 8'(bus.o_MemRead), 8'd0);
        chk({nm, " trap regwrite"}, 8'(bus.o_RegWrite), 8'd0);
        reset_pulse(nm);
`else
        @(negedge clk);
        chk({nm, " nop state"}, 8'(bus.o_State_4), 8'd0);
        chk({nm, " nop trap"}, 8'(bus.o_Trap), 8'd0);
        @(posedge clk);
        #1;
        chk({nm, " nop stays fetch"}, 8'(bus.o_State_4), 8'd0);
`endif
    endtask

    logic [3:0] lw_st [8];
    logic       lw_mr [8];

    initial begin
        //        name    op     fn     z  len seq           xalu sa sb ez  lalu pw ps rw rd m2r mw
        vecs.push_back(mk("add",  6'h00, 6'h20, 0, 4, 24'h016800, 4'd3, 1, 0, 0, 4'd3, 0, 0, 1, 1, 0, 0));
        vecs.push_back(mk("sub",  6'h00, 6'h22, 0, 4, 24'h016800, 4'd4, 1, 0, 0, 4'd4, 0, 0, 1, 1, 0, 0));
        vecs.push_back(mk("and",  6'h00, 6'h24, 0, 4, 24'h016800, 4'd0, 1, 0, 0, 4'd0, 0, 0, 1, 1, 0, 0));
        vecs.push_back(mk("or",   6'h00, 6'h25, 0, 4, 24'h016800, 4'd1, 1, 0, 0, 4'd1, 0, 0, 1, 1, 0, 0));
        vecs.push_back(mk("nor",  6'h00, 6'h27, 0, 4, 24'h016800, 4'd2, 1, 0, 0, 4'd2, 0, 0, 1, 1, 0, 0));
        vecs.push_back(mk("sll",  6'h00, 6'h00, 0, 4, 24'h016800, 4'd5, 1, 0, 0, 4'd5, 0, 0, 1, 1, 0, 0));
        vecs.push_back(mk("srl",  6'h00, 6'h02, 0, 4, 24'h016800, 4'd6, 1, 0, 0, 4'd6, 0, 0, 1, 1, 0, 0));
        vecs.push_back(mk("addi", 6'h08, 6'h00, 0, 4, 24'h017800, 4'd3, 1, 2, 0, 4'd3, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk("andi", 6'h0C, 6'h00, 0, 4, 24'h017800, 4'd0, 1, 2, 1, 4'd0, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk("ori",  6'h0D, 6'h00, 0, 4, 24'h017800, 4'd1, 1, 2, 1, 4'd1, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk("lui",  6'h0F, 6'h00, 0, 4, 24'h017800, 4'd7, 1, 2, 1, 4'd7, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk("lw",   6'h23, 6'h00, 0, 5, 24'h012340, 4'd3, 1, 2, 0, 4'd3, 0, 0, 1, 0, 1, 0));
        vecs.push_back(mk("sw",   6'h2B, 6'h00, 0, 4, 24'h012500, 4'd3, 1, 2, 0, 4'd3, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk("beqz", 6'h04, 6'h00, 1, 3, 24'h019000, 4'd4, 1, 0, 0, 4'd4, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk("beqn", 6'h04, 6'h00, 0, 3, 24'h019000, 4'd4, 1, 0, 0, 4'd4, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk("bnez", 6'h05, 6'h00, 1, 3, 24'h019000, 4'd4, 1, 0, 0, 4'd4, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk("bnen", 6'h05, 6'h00, 0, 3, 24'h019000, 4'd4, 1, 0, 0, 4'd4, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk("j",    6'h02, 6'h00, 0, 3, 24'h01A000, 4'd3, 0, 0, 0, 4'd3, 1, 2, 0, 0, 0, 0));

        // Reset: FETCH forced with handshake high, but no write strobes.
        drive(6'h00, 6'h20, 1'b0, 1'b1);
        #1;
        reset = 1'b1;
        #2;
        chk("reset state", 8'(bus.o_State_4), 8'd0);
        chk("reset pcwrite", 8'(bus.o_PCWrite), 8'd0);
        chk("reset irwrite", 8'(bus.o_IRWrite), 8'd0);
        chk("reset regwrite", 8'(bus.o_RegWrite), 8'd0);
        chk("reset memwrite", 8'(bus.o_MemWrite), 8'd0);
        chk("reset trap", 8'(bus.o_Trap), 8'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        bus.in_MemReady = 1'b0;
        @(posedge clk);
        #1;
        chk("fetch holds without ready", 8'(bus.o_State_4), 8'd0);

        foreach (vecs[i]) run_vec(vecs[i]);

        // lw: one fetch wait state, then two MEMREAD wait states.
        lw_st = '{4'd0, 4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd4};
        lw_mr = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int c = 0; c < 8; c++) begin
            drive(6'h23, 6'h00, 1'b0, lw_mr[c]);
            @(negedge clk);
            chk($sformatf("lw wait state c%0d", c), 8'(bus.o_State_4), 8'(lw_st[c]));
            if (c == 0) begin
                chk("fetch wait irwrite", 8'(bus.o_IRWrite), 8'd0);
                chk("fetch wait pcwrite", 8'(bus.o_PCWrite), 8'd0);
            end
            if (c == 4) begin
                chk("memread wait iord", 8'(bus.o_IorD), 8'd1);
                chk("memread wait memread", 8'(bus.o_MemRead), 8'd1);
            end
            if (c == 7) begin
                chk("memwb memtoreg", 8'(bus.o_MemtoReg), 8'd1);
                chk("memwb regwrite", 8'(bus.o_RegWrite), 8'd1);
                chk("memwb regdst", 8'(bus.o_RegDst), 8'd0);
            end
            @(posedge clk);
            #1;
        end
        chk("lw wait back to fetch", 8'(bus.o_State_4), 8'd0);

        // sw stalled in MEMWRITE, reset asserted between clock edges.
        for (int c = 0; c < 3; c++) begin
            drive(6'h2B, 6'h00, 1'b0, 1'b1);
            @(posedge clk);
            #1;
        end
        bus.in_MemReady = 1'b0;
        @(negedge clk);
        chk("sw stall state", 8'(bus.o_State_4), 8'd5);
        chk("sw stall memwrite", 8'(bus.o_MemWrite), 8'd1);
        bus.in_MemReady = 1'b1;
        reset = 1'b1;
        #1;
        chk("mid-sw reset state", 8'(bus.o_State_4), 8'd0);
        chk("mid-sw reset memwrite", 8'(bus.o_MemWrite), 8'd0);
        chk("mid-sw reset pcwrite", 8'(bus.o_PCWrite), 8'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("post-reset fetch advances", 8'(bus.o_State_4), 8'd1);
        @(posedge clk);
        #1;
        chk("post-reset memaddr", 8'(bus.o_State_4), 8'd2);
        @(posedge clk);
        #1;
        chk("post-reset memwrite", 8'(bus.o_State_4), 8'd5);
        @(posedge clk);
        #1;
        chk("post-reset sw done", 8'(bus.o_State_4), 8'd0);
        bus.in_MemReady = 1'b0;

        run_illegal("bad opcode", 6'h3F, 6'h00, 2);
        run_illegal("bad funct", 6'h00, 6'h3F, 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
